// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with a single-line refill engine.
// Hits return in the same cycle; misses stall the PC and fetch one line over req/gnt/beat.
module icache_dm #(
  parameter int unsigned NUM_LINES      = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  input  logic        invalidate_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        pc_enable_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned Ofs  = $clog2(WORDS_PER_LINE);
  localparam int unsigned Idx  = $clog2(NUM_LINES);
  localparam int unsigned TagW = 32 - Idx - Ofs - 2;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StReq, StRefill} state_e;

  state_e               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [Ofs-1:0]       cnt_q, cnt_d;
  logic                 inv_q, inv_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];
  logic [TagW-1:0]      tag_q [NUM_LINES];

  logic [Ofs-1:0]  pc_word;
  logic [Idx-1:0]  pc_idx, fill_idx;
  logic [TagW-1:0] pc_tag, fill_tag;
  logic            hit, beat, last_beat;
  logic            unused_pc;

  assign pc_word   = pc_i[Ofs+1:2];
  assign pc_idx    = pc_i[Idx+Ofs+1:Ofs+2];
  assign pc_tag    = pc_i[31:Idx+Ofs+2];
  assign fill_idx  = addr_q[Idx+Ofs+1:Ofs+2];
  assign fill_tag  = addr_q[31:Idx+Ofs+2];
  assign unused_pc = ^pc_i[1:0];

  assign hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign beat      = (state_q == StRefill) && mem_rvalid_i;
  assign last_beat = beat && (cnt_q == Ofs'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!hit) state_d = StReq;
      StReq:    if (mem_gnt_i) state_d = StRefill;
      StRefill: if (last_beat) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    instr_valid_o = 1'b0;
    instr_o       = Nop;
    mem_req_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          instr_valid_o = 1'b1;
          instr_o       = data_q[pc_idx][pc_word];
        end
      end
      StReq:   mem_req_o = 1'b1;
      default: ;
    endcase
  end

  assign pc_enable_o = instr_valid_o;
  assign mem_addr_o  = addr_q;

  // Sticky inv_q remembers any invalidate seen while a line is in flight so that
  // line is written but never marked valid.
  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    valid_d = valid_q;
    if (invalidate_i) valid_d = '0;
    unique case (state_q)
      StIdle: begin
        if (!hit) begin
          addr_d = {pc_i[31:Ofs+2], {(Ofs + 2){1'b0}}};
          inv_d  = 1'b0;
        end
      end
      StReq: begin
        if (invalidate_i) inv_d = 1'b1;
        if (mem_gnt_i) cnt_d = '0;
      end
      StRefill: begin
        if (invalidate_i) inv_d = 1'b1;
        if (beat) cnt_d = cnt_q + Ofs'(1);
        if (last_beat && !inv_q && !invalidate_i) valid_d[fill_idx] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && beat) begin
      data_q[fill_idx][cnt_q] <= mem_rdata_i;
      if (last_beat) tag_q[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped instruction cache and fetch controller sitting between the program counter and instruction memory. It consumes the PC's fetch address, returns the instruction on a hit in the same cycle, and on a miss deasserts the PC enable and refills one line from memory over a request/grant/beat handshake. It is the consumer end of the PC interface: its `pc_enable_o` drives the PC's `enable_i`.

## Interface
- `NUM_LINES`, 16: number of cache lines; power of two, at least 2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, at least 2.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `pc_i`  in  32  fetch byte address from the PC; bits [1:0] ignored.
- `invalidate_i`  in  1  fence.i: clear all valid bits.
- `instr_o`  out  32  fetched instruction; 32'h0000_0013 (NOP) when `instr_valid_o`=0.
- `instr_valid_o`  out  1  `instr_o` is the word at `pc_i`.
- `pc_enable_o`  out  1  PC advance permission; equals `instr_valid_o`.
- `mem_req_o`  out  1  line-fill request.
- `mem_addr_o`  out  32  line-aligned refill address.
- `mem_gnt_i`  in  1  memory accepts the request.
- `mem_rvalid_i`  in  1  refill beat valid.
- `mem_rdata_i`  in  32  refill beat data.

## Operation
- Address split: OFS=log2(WORDS_PER_LINE), IDX=log2(NUM_LINES). Word = `pc_i`[OFS+1:2], index = `pc_i`[IDX+OFS+1:OFS+2], tag = `pc_i`[31:IDX+OFS+2].
- Storage: data array NUM_LINES×WORDS_PER_LINE×32, tag array, valid bit per line. Valid bits reset to 0; data and tag arrays are not reset.
- FSM states IDLE, REQ, REFILL.
- IDLE: combinational lookup. Hit = valid[index] && tag match. On hit: `instr_valid_o`=1, `pc_enable_o`=1, `instr_o`=data[index][word]. On miss: outputs invalid/NOP, latch `{pc_i[31:OFS+2], zeros}` into the refill address register, go to REQ.
- REQ: `mem_req_o`=1, `mem_addr_o` = latched address, held stable until `mem_gnt_i` is sampled high, then go to REFILL with beat counter 0.
- REFILL: each cycle with `mem_rvalid_i`=1 writes `mem_rdata_i` into data[latched index][counter] and increments the counter. Beats arrive in order, word 0 first. On beat WORDS_PER_LINE-1: write tag, set valid (subject to the invalidate rule below), go to IDLE.
- `mem_rvalid_i` outside REFILL and `mem_gnt_i` outside REQ are ignored.
- Invalidate: `invalidate_i`=1 at any edge clears all valid bits. If it is asserted at any edge during REQ or REFILL, including the last-beat edge, the in-flight line completes its data writes but its valid bit is not set. A sticky flag, cleared on entry to REQ, tracks this. Invalidate in IDLE coincident with a miss: the miss proceeds normally.
- Refill uses the latched address. If `pc_i` changes while stalled, the lookup after return uses the current `pc_i` and may miss again.
- Reset at any state returns to IDLE, clears valid bits, beat counter, sticky flag, and the refill address register (to 0). In-flight beats after reset are ignored.

## Timing
- Reset values: `instr_valid_o`=0, `pc_enable_o`=0, `instr_o`=32'h0000_0013, `mem_req_o`=0, `mem_addr_o`=0.
- Hit latency 0: instruction is valid in the same cycle `pc_i` is presented.
- Miss at cycle t (IDLE), then `mem_req_o` rises at t+1. With gnt at t+1 and back-to-back beats from t+2, the last beat is at t+1+WORDS_PER_LINE and the hit occurs at t+2+WORDS_PER_LINE. With default parameters the minimum miss penalty is 6 stall cycles.
- `pc_enable_o` is low for every cycle in REQ and REFILL, and for the IDLE miss cycle.
- `mem_addr_o` is valid only while `mem_req_o`=1. It holds the latched value otherwise.
- Gaps (`mem_rvalid_i`=0) during REFILL stretch the refill without limit. There is no timeout.

## Test plan
- Cold miss at `pc_i`=0x0000_0040, gnt immediate, beats 0xA0..0xA3 → `mem_addr_o`=0x40 for 1 cycle, `pc_enable_o` low for 6 cycles, then `instr_o`=0xA0, valid. Stepping `pc_i` to 0x44, 0x48, 0x4C yields hits 0xA1..0xA3 with 0 latency.
- Conflict: after the above, fetch 0x0000_0140 (same index, new tag) → miss, refill, and line replaced. Re-fetching 0x40 then misses again.
- Gnt delayed 3 cycles and beats with 2-cycle gaps → `mem_req_o`/`mem_addr_o` stable through the delay, counter advances only on `rvalid`, and a correct line is installed.
- `invalidate_i` pulsed during beat 2 of a refill → refill completes, the next IDLE lookup misses and re-requests the same address. `invalidate_i` in IDLE after a fill → next fetch misses.
- `rst_ni` low mid-REFILL with stray `mem_rvalid_i` pulses afterwards → all outputs at reset values, FSM IDLE, the first fetch misses and requests a refill.
- `pc_i`=0x0000_0043 (misaligned) → treated as 0x40: hit returns word 0.
